// File: rtl/video_ram_banked_pkg.sv
// rtl/video_ram_banked_pkg.sv - shared FSM encodings, op modes and parameter checks for the banked video RAM
package video_ram_banked_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL_WR,
        ST_CP_RD,
        ST_CP_WAIT,
        ST_CP_WR,
        ST_DONE
    } vram_state_t;

    localparam logic OP_FILL = 1'b0;
    localparam logic OP_COPY = 1'b1;

    function automatic bit read_latency_ok(input int rl);
        return (rl == 1) || (rl == 2);
    endfunction

    function automatic bit num_banks_ok(input int nb);
        return (nb == 1) || (nb == 2) || (nb == 4) || (nb == 8);
    endfunction

endpackage

// File: rtl/video_ram_banked_vram_bank.sv
// rtl/video_ram_banked_vram_bank.sv - one read-first dual-port bank, port A read/write, port B read-only
module vram_bank
    import video_ram_banked_pkg::*;
#(
    parameter int BANK_AW      = 15,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_en,
    input  logic                  a_we,
    input  logic [BANK_AW-1:0]    a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic [DATA_WIDTH-1:0] a_q,
    input  logic                  b_en,
    input  logic [BANK_AW-1:0]    b_addr,
    output logic [DATA_WIDTH-1:0] b_q
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<BANK_AW)-1];
    logic [DATA_WIDTH-1:0] r_a_q1;
    logic [DATA_WIDTH-1:0] r_b_q1;

    always_ff @(posedge clk) begin
        if (a_en && a_we) begin
            r_mem[a_addr] <= a_din;
        end
    end

    // Both read registers sample the array before this edge's write lands: read-first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_q1 <= '0;
            r_b_q1 <= '0;
        end else begin
            if (a_en) begin
                r_a_q1 <= r_mem[a_addr];
            end
            if (b_en) begin
                r_b_q1 <= r_mem[b_addr];
            end
        end
    end

    if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
        $error("vram_bank: READ_LATENCY must be 1 or 2");
    end

    if (READ_LATENCY == 2) begin : g_out_reg
        logic [DATA_WIDTH-1:0] r_a_q2;
        logic [DATA_WIDTH-1:0] r_b_q2;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_a_q2 <= '0;
                r_b_q2 <= '0;
            end else begin
                r_a_q2 <= r_a_q1;
                r_b_q2 <= r_b_q1;
            end
        end

        assign a_q = r_a_q2;
        assign b_q = r_b_q2;
    end else begin : g_no_out_reg
        assign a_q = r_a_q1;
        assign b_q = r_b_q1;
    end

endmodule

// File: rtl/video_ram_banked.sv
// rtl/video_ram_banked.sv - banked video RAM with CPU port, video fetch port and fill/copy engine
module video_ram_banked
    import video_ram_banked_pkg::*;
#(
    parameter  int BANK_AW      = 15,
    parameter  int DATA_WIDTH   = 8,
    parameter  int NUM_BANKS    = 2,
    parameter  int READ_LATENCY = 1,
    localparam int SEL_BITS     = $clog2(NUM_BANKS),
    localparam int AW           = BANK_AW + SEL_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [AW-1:0]         a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic [DATA_WIDTH-1:0] a_dout,
    output logic                  a_valid,
    input  logic                  b_req,
    input  logic [AW-1:0]         b_addr,
    output logic [DATA_WIDTH-1:0] b_dout,
    output logic                  b_valid,
    input  logic                  op_start,
    input  logic                  op_copy,
    input  logic [AW-1:0]         op_src,
    input  logic [AW-1:0]         op_dst,
    input  logic [AW:0]           op_len,
    input  logic [DATA_WIDTH-1:0] op_fill,
    output logic                  op_busy,
    output logic                  op_done
);

    localparam int SW = (SEL_BITS > 0) ? SEL_BITS : 1;

    function automatic logic [SW-1:0] bank_of(input logic [AW-1:0] addr);
        return SW'(addr >> BANK_AW);
    endfunction

    if (!num_banks_ok(NUM_BANKS)) begin : g_bad_banks
        $error("video_ram_banked: NUM_BANKS must be 1, 2, 4 or 8");
    end

    vram_state_t           r_state;
    logic [AW-1:0]         r_src;
    logic [AW-1:0]         r_dst;
    logic [AW:0]           r_cnt;
    logic                  r_copy;
    logic [DATA_WIDTH-1:0] r_fill;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [1:0]            r_wait;
    logic [SW-1:0]         r_cp_bank;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_eng_wr;
    logic                  w_eng_rd;
    logic                  w_a_en;
    logic                  w_a_we;
    logic [AW-1:0]         w_a_addr;
    logic [DATA_WIDTH-1:0] w_a_din;
    logic [SW-1:0]         w_a_sel;
    logic                  w_b_en;
    logic [AW-1:0]         w_b_addr;
    logic [SW-1:0]         w_b_sel;

    logic [DATA_WIDTH-1:0] w_a_q [NUM_BANKS];
    logic [DATA_WIDTH-1:0] w_b_q [NUM_BANKS];

    // The engine only gets a port in cycles its owner leaves idle.
    always_comb begin
        w_eng_wr = ((r_state == ST_FILL_WR) || (r_state == ST_CP_WR)) && !a_req;
        w_eng_rd = (r_state == ST_CP_RD) && !b_req;

        w_a_en   = a_req || w_eng_wr;
        w_a_we   = a_req ? a_we : 1'b1;
        w_a_addr = a_req ? a_addr : r_dst;
        w_a_din  = a_req ? a_din : ((r_copy == OP_COPY) ? r_hold : r_fill);
        w_a_sel  = bank_of(w_a_addr);

        w_b_en   = b_req || w_eng_rd;
        w_b_addr = b_req ? b_addr : r_src;
        w_b_sel  = bank_of(w_b_addr);
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        vram_bank #(
            .BANK_AW      (BANK_AW),
            .DATA_WIDTH   (DATA_WIDTH),
            .READ_LATENCY (READ_LATENCY)
        ) u_bank (
            .clk    (clk),
            .rst    (rst),
            .a_en   (w_a_en && (w_a_sel == SW'(g))),
            .a_we   (w_a_we),
            .a_addr (w_a_addr[BANK_AW-1:0]),
            .a_din  (w_a_din),
            .a_q    (w_a_q[g]),
            .b_en   (w_b_en && (w_b_sel == SW'(g))),
            .b_addr (w_b_addr[BANK_AW-1:0]),
            .b_q    (w_b_q[g])
        );
    end

    // Valid and bank-select pipelines track only external reads, never engine traffic.
    logic [READ_LATENCY-1:0]         r_a_vpipe;
    logic [READ_LATENCY-1:0]         r_b_vpipe;
    logic [READ_LATENCY-1:0][SW-1:0] r_a_spipe;
    logic [READ_LATENCY-1:0][SW-1:0] r_b_spipe;
    logic [DATA_WIDTH-1:0]           r_a_hold;
    logic [DATA_WIDTH-1:0]           r_b_hold;

    logic [DATA_WIDTH-1:0] w_a_rd_q;
    logic [DATA_WIDTH-1:0] w_b_rd_q;
    logic [DATA_WIDTH-1:0] w_eng_q;

    assign w_a_rd_q = w_a_q[r_a_spipe[READ_LATENCY-1]];
    assign w_b_rd_q = w_b_q[r_b_spipe[READ_LATENCY-1]];
    assign w_eng_q  = w_b_q[r_cp_bank];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_vpipe <= '0;
            r_b_vpipe <= '0;
            r_a_spipe <= '0;
            r_b_spipe <= '0;
            r_a_hold  <= '0;
            r_b_hold  <= '0;
        end else begin
            r_a_vpipe[0] <= a_req && !a_we;
            r_b_vpipe[0] <= b_req;
            r_a_spipe[0] <= w_a_sel;
            r_b_spipe[0] <= w_b_sel;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_a_vpipe[i] <= r_a_vpipe[i-1];
                r_b_vpipe[i] <= r_b_vpipe[i-1];
                r_a_spipe[i] <= r_a_spipe[i-1];
                r_b_spipe[i] <= r_b_spipe[i-1];
            end
            if (r_a_vpipe[READ_LATENCY-1]) begin
                r_a_hold <= w_a_rd_q;
            end
            if (r_b_vpipe[READ_LATENCY-1]) begin
                r_b_hold <= w_b_rd_q;
            end
        end
    end

    assign a_valid = r_a_vpipe[READ_LATENCY-1];
    assign b_valid = r_b_vpipe[READ_LATENCY-1];
    assign a_dout  = a_valid ? w_a_rd_q : r_a_hold;
    assign b_dout  = b_valid ? w_b_rd_q : r_b_hold;

    // A new op may also be accepted in DONE, since op_busy is already low there.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_src     <= '0;
            r_dst     <= '0;
            r_cnt     <= '0;
            r_copy    <= OP_FILL;
            r_fill    <= '0;
            r_hold    <= '0;
            r_wait    <= '0;
            r_cp_bank <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_state <= ST_IDLE;
                    if (op_start) begin
                        r_src  <= op_src;
                        r_dst  <= op_dst;
                        r_cnt  <= op_len;
                        r_copy <= op_copy;
                        r_fill <= op_fill;
                        if (op_len == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= (op_copy == OP_COPY) ? ST_CP_RD : ST_FILL_WR;
                        end
                    end
                end
                ST_FILL_WR, ST_CP_WR: begin
                    if (!a_req) begin
                        r_dst <= r_dst + AW'(1);
                        r_cnt <= r_cnt - (AW+1)'(1);
                        if (r_cnt == (AW+1)'(1)) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (r_state == ST_CP_WR) begin
                            r_state <= ST_CP_RD;
                        end
                    end
                end
                ST_CP_RD: begin
                    if (!b_req) begin
                        r_src     <= r_src + AW'(1);
                        r_cp_bank <= bank_of(r_src);
                        r_wait    <= '0;
                        r_state   <= ST_CP_WAIT;
                    end
                end
                ST_CP_WAIT: begin
                    if (r_wait == 2'(READ_LATENCY - 1)) begin
                        r_hold  <= w_eng_q;
                        r_state <= ST_CP_WR;
                    end else begin
                        r_wait <= r_wait + 2'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign op_busy = r_busy;
    assign op_done = r_done;

endmodule

// File: tb/tb_video_ram_banked.sv
// tb/tb_video_ram_banked.sv - self-checking bench for video_ram_banked with a flat-memory reference model
module tb_video_ram_banked;

    localparam int BANK_AW = 15;
    localparam int DW      = 8;
    localparam int NB      = 2;
    localparam int RL      = 2;
    localparam int AW      = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_din, a_dout;
    logic          a_valid;
    logic          b_req;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_dout;
    logic          b_valid;
    logic          op_start, op_copy;
    logic [AW-1:0] op_src, op_dst;
    logic [AW:0]   op_len;
    logic [DW-1:0] op_fill;
    logic          op_busy, op_done;

    int passed = 0;
    int total  = 0;

    logic [DW-1:0] model [int];

    always #5 clk = ~clk;

    video_ram_banked #(
        .BANK_AW(BANK_AW), .DATA_WIDTH(DW), .NUM_BANKS(NB), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout), .a_valid(a_valid),
        .b_req(b_req), .b_addr(b_addr), .b_dout(b_dout), .b_valid(b_valid),
        .op_start(op_start), .op_copy(op_copy), .op_src(op_src), .op_dst(op_dst),
        .op_len(op_len), .op_fill(op_fill), .op_busy(op_busy), .op_done(op_done)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        a_req = 1'b1; a_we = 1'b1; a_addr = addr; a_din = data;
        tick();
        a_req = 1'b0; a_we = 1'b0;
        model[int'(addr)] = data;
    endtask

    task automatic cpu_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                            output int lat, output bit one_shot);
        data = '0; lat = -1; one_shot = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = addr;
        tick();
        a_req = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (a_valid) begin
                lat = c; data = a_dout;
                tick();
                one_shot = !a_valid;
                break;
            end
            tick();
        end
    endtask

    task automatic vid_read(input logic [AW-1:0] addr, output logic [DW-1:0] data, output int lat);
        data = '0; lat = -1;
        b_req = 1'b1; b_addr = addr;
        tick();
        b_req = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (b_valid) begin
                lat = c; data = b_dout;
                tick();
                break;
            end
            tick();
        end
    endtask

    task automatic start_op(input logic copy, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                            input int len, input logic [DW-1:0] fill);
        op_start = 1'b1; op_copy = copy; op_src = src; op_dst = dst;
        op_len = (AW+1)'(len); op_fill = fill;
        tick();
        op_start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int c = 1; c <= 300; c++) begin
            if (op_done) begin
                cyc = c;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; a_req = 0; a_we = 0; a_addr = '0; a_din = '0; b_req = 0; b_addr = '0;
        op_start = 0; op_copy = 0; op_src = '0; op_dst = '0; op_len = '0; op_fill = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        total++; if (a_dout !== 8'h00) $display("FAIL reset_a_dout: got %h want 00", a_dout); else passed++;
        total++; if (b_dout !== 8'h00) $display("FAIL reset_b_dout: got %h want 00", b_dout); else passed++;
        total++; if (a_valid !== 1'b0) $display("FAIL reset_a_valid: got %b want 0", a_valid); else passed++;
        total++; if (b_valid !== 1'b0) $display("FAIL reset_b_valid: got %b want 0", b_valid); else passed++;
        total++; if (op_busy !== 1'b0) $display("FAIL reset_op_busy: got %b want 0", op_busy); else passed++;
        total++; if (op_done !== 1'b0) $display("FAIL reset_op_done: got %b want 0", op_done); else passed++;
    endtask

    task automatic test_cpu_rw();
        logic [DW-1:0] d;
        logic [AW-1:0] addr;
        int lat;
        bit os;
        cpu_write(16'h0001, 8'h5A);
        cpu_read(16'h0001, d, lat, os);
        total++; if (d !== 8'h5A) $display("FAIL cpu_rd_5a: got %h want 5a", d); else passed++;
        total++; if (lat !== RL) $display("FAIL cpu_rd_latency: got %0d want %0d", lat, RL); else passed++;
        total++; if (os !== 1'b1) $display("FAIL cpu_valid_width: got %b want 1", os); else passed++;
        for (int i = 0; i < 6; i++) begin
            addr = AW'($urandom);
            cpu_write(addr, DW'($urandom));
            cpu_read(addr, d, lat, os);
            total++;
            if (d !== model[int'(addr)] || lat !== RL)
                $display("FAIL cpu_rand_rw[%0d]: addr %h got %h lat %0d want %h lat %0d",
                         i, addr, d, lat, model[int'(addr)], RL);
            else passed++;
        end
    endtask

    task automatic test_collision();
        logic [DW-1:0] d, old;
        int lat;
        bit os;
        bit a_seen;
        cpu_write(16'h8000, 8'h22);
        cpu_write(16'h0000, 8'h33);
        old = model[16'h8000];
        a_req = 1; a_we = 1; a_addr = 16'h8000; a_din = 8'h11;
        b_req = 1; b_addr = 16'h8000;
        tick();
        a_req = 0; a_we = 0; b_req = 0;
        model[16'h8000] = 8'h11;
        lat = -1; d = '0; a_seen = 0;
        for (int c = 1; c <= 10; c++) begin
            if (a_valid) a_seen = 1;
            if (b_valid) begin
                lat = c; d = b_dout;
                break;
            end
            tick();
        end
        tick();
        total++; if (d !== old) $display("FAIL collide_read_first: got %h want %h", d, old); else passed++;
        total++; if (lat !== RL) $display("FAIL collide_latency: got %0d want %0d", lat, RL); else passed++;
        total++; if (a_seen !== 1'b0) $display("FAIL collide_no_a_valid: got %b want 0", a_seen); else passed++;
        vid_read(16'h8000, d, lat);
        total++; if (d !== model[16'h8000]) $display("FAIL collide_new_data: got %h want %h", d, model[16'h8000]); else passed++;
        cpu_read(16'h0000, d, lat, os);
        total++; if (d !== model[16'h0000]) $display("FAIL collide_bank0_intact: got %h want %h", d, model[16'h0000]); else passed++;
    endtask

    task automatic test_fill(input logic [AW-1:0] dst, input int len, input logic [DW-1:0] fill);
        logic [DW-1:0] d;
        int lat, cyc;
        bit os;
        cpu_write(dst - AW'(1), DW'($urandom));
        cpu_write(dst + AW'(len), DW'($urandom));
        start_op(1'b0, '0, dst, len, fill);
        total++; if (op_busy !== 1'b1) $display("FAIL fill_busy_next: got %b want 1", op_busy); else passed++;
        wait_done(cyc);
        total++; if (cyc !== len + 1) $display("FAIL fill_done_cycle: got %0d want %0d", cyc, len + 1); else passed++;
        total++; if (op_busy !== 1'b0) $display("FAIL fill_busy_at_done: got %b want 0", op_busy); else passed++;
        tick();
        for (int i = 0; i < len; i++) model[int'(AW'(dst + AW'(i)))] = fill;
        for (int i = -1; i <= len; i++) begin
            cpu_read(AW'(dst + AW'(i)), d, lat, os);
            total++;
            if (d !== model[int'(AW'(dst + AW'(i)))])
                $display("FAIL fill_mem[%h]: got %h want %h", AW'(dst + AW'(i)), d, model[int'(AW'(dst + AW'(i)))]);
            else passed++;
        end
    endtask

    task automatic test_copy_contended();
        bit pat [0:127];
        int exp_done, done_cyc, av_seen, bv_seen;
        logic [DW-1:0] d;
        int lat;
        bit os;
        for (int i = 0; i < 3; i++) cpu_write(AW'(16'h0100 + i), DW'($urandom));
        for (int i = 0; i < 3; i++) cpu_write(AW'(16'h0200 + i), DW'($urandom));
        pat[0] = 0;
        for (int k = 1; k < 128; k++) pat[k] = 1'($urandom_range(0, 1));
        pat[2 + RL] = 1;
        exp_done = 1;
        for (int i = 0; i < 3; i++) begin
            exp_done += 1 + RL;
            while (pat[exp_done]) exp_done++;
            exp_done++;
        end
        op_start = 1; op_copy = 1; op_src = 16'h0100; op_dst = 16'h0200; op_len = 17'd3; op_fill = '0;
        tick();
        op_start = 0;
        done_cyc = -1; av_seen = 0; bv_seen = 0;
        for (int k = 1; k < 128; k++) begin
            if (a_valid) av_seen++;
            if (b_valid) bv_seen++;
            if (op_done) begin
                done_cyc = k;
                break;
            end
            a_req = pat[k]; a_we = 1; a_addr = AW'(16'h3000 + (k % 8)); a_din = DW'($urandom);
            if (pat[k]) model[int'(a_addr)] = a_din;
            tick();
        end
        a_req = 0; a_we = 0;
        tick();
        for (int i = 0; i < 3; i++) model[16'h0200 + i] = model[16'h0100 + i];
        total++; if (done_cyc !== exp_done) $display("FAIL copy_done_cycle: got %0d want %0d", done_cyc, exp_done); else passed++;
        total++; if (av_seen !== 0) $display("FAIL copy_no_a_valid: got %0d want 0", av_seen); else passed++;
        total++; if (bv_seen !== 0) $display("FAIL copy_no_b_valid: got %0d want 0", bv_seen); else passed++;
        for (int i = 0; i < 3; i++) begin
            cpu_read(AW'(16'h0200 + i), d, lat, os);
            total++; if (d !== model[16'h0200 + i]) $display("FAIL copy_dst[%0d]: got %h want %h", i, d, model[16'h0200 + i]); else passed++;
        end
        for (int i = 0; i < 8; i += 3) begin
            cpu_read(AW'(16'h3000 + i), d, lat, os);
            total++; if (d !== model[16'h3000 + i]) $display("FAIL copy_cpu_wr[%0d]: got %h want %h", i, d, model[16'h3000 + i]); else passed++;
        end
    endtask

    task automatic test_copy_overlap();
        logic [DW-1:0] d;
        int lat, cyc;
        bit os;
        for (int i = 0; i < 5; i++) cpu_write(AW'(16'h0600 + i), DW'($urandom));
        start_op(1'b1, 16'h0600, 16'h0601, 3, '0);
        wait_done(cyc);
        tick();
        total++; if (cyc !== 1 + 3 * (2 + RL)) $display("FAIL overlap_done_cycle: got %0d want %0d", cyc, 1 + 3 * (2 + RL)); else passed++;
        for (int i = 0; i < 3; i++) model[16'h0601 + i] = model[16'h0600 + i];
        for (int i = 0; i < 5; i++) begin
            cpu_read(AW'(16'h0600 + i), d, lat, os);
            total++; if (d !== model[16'h0600 + i]) $display("FAIL overlap_mem[%0d]: got %h want %h", i, d, model[16'h0600 + i]); else passed++;
        end
    endtask

    task automatic test_len_zero();
        logic [DW-1:0] d;
        int lat;
        bit os;
        cpu_write(16'h0700, 8'h77);
        start_op(1'b0, '0, 16'h0700, 0, 8'hEE);
        total++; if (op_done !== 1'b1) $display("FAIL len0_done: got %b want 1", op_done); else passed++;
        total++; if (op_busy !== 1'b0) $display("FAIL len0_busy: got %b want 0", op_busy); else passed++;
        tick();
        total++; if (op_done !== 1'b0) $display("FAIL len0_done_pulse: got %b want 0", op_done); else passed++;
        total++; if (op_busy !== 1'b0) $display("FAIL len0_busy_after: got %b want 0", op_busy); else passed++;
        cpu_read(16'h0700, d, lat, os);
        total++; if (d !== model[16'h0700]) $display("FAIL len0_mem: got %h want %h", d, model[16'h0700]); else passed++;
    endtask

    task automatic test_reset_mid_copy();
        logic [DW-1:0] d;
        int lat, done_seen, rst_cyc;
        bit os, busy_before;
        for (int i = 0; i < 5; i++) cpu_write(AW'(16'h0400 + i), DW'($urandom));
        for (int i = 0; i < 5; i++) cpu_write(AW'(16'h0500 + i), DW'($urandom));
        rst_cyc = 2 * (2 + RL) + 1;
        start_op(1'b1, 16'h0400, 16'h0500, 5, '0);
        done_seen = 0; busy_before = 0;
        for (int k = 1; k < rst_cyc; k++) begin
            if (op_done) done_seen++;
            busy_before = op_busy;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (busy_before !== 1'b1) $display("FAIL rstcp_busy_before: got %b want 1", busy_before); else passed++;
        total++; if (op_busy !== 1'b0) $display("FAIL rstcp_busy_after: got %b want 0", op_busy); else passed++;
        for (int k = 0; k < 20; k++) begin
            if (op_done) done_seen++;
            tick();
        end
        total++; if (done_seen !== 0) $display("FAIL rstcp_no_done: got %0d want 0", done_seen); else passed++;
        for (int i = 0; i < 2; i++) model[16'h0500 + i] = model[16'h0400 + i];
        for (int i = 0; i < 5; i++) begin
            cpu_read(AW'(16'h0500 + i), d, lat, os);
            total++; if (d !== model[16'h0500 + i]) $display("FAIL rstcp_dst[%0d]: got %h want %h", i, d, model[16'h0500 + i]); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] pool [8];
        bit            exp_av [0:63], exp_bv [0:63];
        logic [DW-1:0] exp_ad [0:63], exp_bd [0:63];
        logic [DW-1:0] last_a, last_b;
        bit            a_seen, b_seen;
        int            op;
        logic [AW-1:0] aa, ba;
        localparam int N = 48;
        pool = '{16'h0010, 16'h0011, 16'h7FFF, 16'h8000, 16'h8001, 16'hFFFF, 16'h1234, 16'h9234};
        for (int i = 0; i < 8; i++) cpu_write(pool[i], DW'($urandom));
        repeat (RL + 1) tick();
        for (int k = 0; k < 64; k++) begin
            exp_av[k] = 0; exp_bv[k] = 0; exp_ad[k] = '0; exp_bd[k] = '0;
        end
        a_seen = 0; b_seen = 0; last_a = '0; last_b = '0;
        for (int k = 0; k < N + RL + 1; k++) begin
            total++;
            if (a_valid !== exp_av[k] || (exp_av[k] && a_dout !== exp_ad[k]) || (!exp_av[k] && a_seen && a_dout !== last_a))
                $display("FAIL b2b_port_a[%0d]: valid %b data %h want valid %b data %h",
                         k, a_valid, a_dout, exp_av[k], exp_av[k] ? exp_ad[k] : last_a);
            else passed++;
            if (exp_av[k]) begin last_a = exp_ad[k]; a_seen = 1; end
            total++;
            if (b_valid !== exp_bv[k] || (exp_bv[k] && b_dout !== exp_bd[k]) || (!exp_bv[k] && b_seen && b_dout !== last_b))
                $display("FAIL b2b_port_b[%0d]: valid %b data %h want valid %b data %h",
                         k, b_valid, b_dout, exp_bv[k], exp_bv[k] ? exp_bd[k] : last_b);
            else passed++;
            if (exp_bv[k]) begin last_b = exp_bd[k]; b_seen = 1; end
            a_req = 0; a_we = 0; b_req = 0;
            if (k < N) begin
                op = $urandom_range(0, 2);
                aa = pool[$urandom_range(0, 7)];
                ba = pool[$urandom_range(0, 7)];
                if ($urandom_range(0, 1) == 1) begin
                    b_req = 1; b_addr = ba;
                    exp_bv[k + RL] = 1; exp_bd[k + RL] = model[int'(ba)];
                end
                if (op == 1) begin
                    a_req = 1; a_we = 0; a_addr = aa;
                    exp_av[k + RL] = 1; exp_ad[k + RL] = model[int'(aa)];
                end else if (op == 2) begin
                    a_req = 1; a_we = 1; a_addr = aa; a_din = DW'($urandom);
                    model[int'(aa)] = a_din;
                end
            end
            tick();
        end
        a_req = 0; a_we = 0; b_req = 0;
    endtask

    initial begin
        test_reset();
        test_cpu_rw();
        test_collision();
        test_fill(16'h7FFE, 4, 8'hAA);
        test_fill(16'hFFFE, $urandom_range(3, 6), DW'($urandom));
        test_copy_contended();
        test_copy_overlap();
        test_len_zero();
        test_reset_mid_copy();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
